// File: rtl/noc_pkg.sv
// Shared types and helpers for the NoC virtual-channel input port.
package noc_pkg;

  localparam int FLIT_W_DEF = 16;
  localparam int NUM_VC_DEF = 2;

  // Index width that stays at least 1 bit wide for a single-VC port
  function automatic int vc_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [FLIT_W_DEF-1:0]             flit_t;
  typedef logic [vc_width(NUM_VC_DEF)-1:0]   vc_id_t;

  typedef struct packed {
    logic   valid;
    vc_id_t vc;
  } credit_t;

endpackage

// File: rtl/noc_vc_fifo.sv
// Single-VC circular flit FIFO; push/pop arrive pre-qualified from the port.
module noc_vc_fifo #(
  parameter  int W     = 16,
  parameter  int DEPTH = 5,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [PW-1:0]           rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  // DEPTH need not be a power of two, so wrap on an explicit compare
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    rd_d  = pop  ? nxt(rd_q) : rd_q;
    wr_d  = push ? nxt(wr_q) : wr_q;
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;

endmodule

// File: rtl/noc_vc_input_port.sv
// Multi-VC router input port: per-VC FIFOs, head mux, credit return, sticky errors.
// Optional per-VC flit / drop counters when NOC_INPORT_STATS_EN is defined.
module noc_vc_input_port
  import noc_pkg::*;
#(
  parameter  int FLIT_W = FLIT_W_DEF,
  parameter  int DEPTH  = 5,
  parameter  int NUM_VC = NUM_VC_DEF,
  localparam int VC_W   = vc_width(NUM_VC),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLIT_W-1:0] data_i,
  input  logic [VC_W-1:0]   wr_vc_i,
  input  logic              write_en_i,
  input  logic [VC_W-1:0]   rd_vc_i,
  input  logic              shift_i,
  output logic [FLIT_W-1:0] data_o,
  output logic [NUM_VC-1:0] read_valid_o,
  output logic [NUM_VC-1:0] full_o,
  output logic              credit_o,
  output logic [VC_W-1:0]   credit_vc_o,
  output logic              ovf_err_o,
  output logic              udf_err_o
`ifdef NOC_INPORT_STATS_EN
  ,output logic [NUM_VC-1:0][31:0] flit_cnt_o
  ,output logic [31:0]             drop_cnt_o
`endif
);

  typedef struct packed {
    logic            valid;
    logic [VC_W-1:0] vc;
  } crd_t;

  logic [NUM_VC-1:0]             push_vec, pop_vec;
  logic [NUM_VC-1:0]             fifo_empty, fifo_full;
  logic [NUM_VC-1:0][FLIT_W-1:0] fifo_dout;
  logic [NUM_VC-1:0][CW-1:0]     fifo_cnt;
  logic                          rd_empty, push_drop, pop_miss;
  crd_t                          crd_q, crd_d;
  logic                          ovf_q, udf_q;

  generate
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      // Same-VC pop frees a slot this cycle, so a push at full is still legal
      assign pop_vec[v]  = shift_i && (rd_vc_i == VC_W'(v)) && !fifo_empty[v];
      assign push_vec[v] = write_en_i && (wr_vc_i == VC_W'(v)) &&
                           (!fifo_full[v] || pop_vec[v]);

      noc_vc_fifo #(.W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_vec[v]),
        .pop   (pop_vec[v]),
        .din   (data_i),
        .dout  (fifo_dout[v]),
        .empty (fifo_empty[v]),
        .full  (fifo_full[v]),
        .count (fifo_cnt[v])
      );

      a_cnt_empty: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_empty[v] == (fifo_cnt[v] == '0));
    end
  endgenerate

  // Out-of-range VC indices (non-power-of-two NUM_VC) read as empty
  always_comb begin
    data_o   = '0;
    rd_empty = 1'b1;
    for (int v = 0; v < NUM_VC; v++) begin
      if (rd_vc_i == VC_W'(v)) begin
        data_o   = fifo_dout[v];
        rd_empty = fifo_empty[v];
      end
    end
  end

  assign push_drop = write_en_i && !(|push_vec);
  assign pop_miss  = shift_i && rd_empty;

  always_comb begin
    crd_d       = crd_q;
    crd_d.valid = |pop_vec;
    if (|pop_vec) crd_d.vc = rd_vc_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crd_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      crd_q <= crd_d;
      ovf_q <= ovf_q | push_drop;
      udf_q <= udf_q | pop_miss;
    end
  end

  assign read_valid_o = ~fifo_empty;
  assign full_o       = fifo_full;
  assign credit_o     = crd_q.valid;
  assign credit_vc_o  = crd_q.vc;
  assign ovf_err_o    = ovf_q;
  assign udf_err_o    = udf_q;

`ifdef NOC_INPORT_STATS_EN
  logic [NUM_VC-1:0][31:0] flit_cnt_q;
  logic [31:0]             drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++)
        if (push_vec[v]) flit_cnt_q[v] <= flit_cnt_q[v] + 32'd1;
      if (push_drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign flit_cnt_o = flit_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_noc_vc_input_port.sv
// Directed table-driven bench for noc_vc_input_port (FLIT_W=16, DEPTH=5, NUM_VC=2).
module tb_noc_vc_input_port;

  logic        clk, rst_n;
  logic [15:0] data_i, data_o;
  logic        wr_vc_i, rd_vc_i, write_en_i, shift_i;
  logic [1:0]  read_valid_o, full_o;
  logic        credit_o, credit_vc_o, ovf_err_o, udf_err_o;
`ifdef NOC_INPORT_STATS_EN
  logic [1:0][31:0] flit_cnt_o;
  logic [31:0]      drop_cnt_o;
`endif

  noc_vc_input_port #(.FLIT_W(16), .DEPTH(5), .NUM_VC(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_i       (data_i),
    .wr_vc_i      (wr_vc_i),
    .write_en_i   (write_en_i),
    .rd_vc_i      (rd_vc_i),
    .shift_i      (shift_i),
    .data_o       (data_o),
    .read_valid_o (read_valid_o),
    .full_o       (full_o),
    .credit_o     (credit_o),
    .credit_vc_o  (credit_vc_o),
    .ovf_err_o    (ovf_err_o),
    .udf_err_o    (udf_err_o)
`ifdef NOC_INPORT_STATS_EN
    ,.flit_cnt_o  (flit_cnt_o)
    ,.drop_cnt_o  (drop_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        wvc;
    logic [15:0] din;
    logic        sh;
    logic        rvc;
    logic        chk_data;
    logic [15:0] exp_data;
    logic [1:0]  exp_rv;
    logic [1:0]  exp_full;
    logic        exp_cr;
    logic        exp_cvc;
    logic        exp_ovf;
    logic        exp_udf;
  } vec_t;

  vec_t vq[$];
  int   checks   = 0;
  int   failures = 0;
  int   credits  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic wvc, input logic [15:0] din,
                     input logic sh, input logic rvc, input logic cd, input logic [15:0] ed,
                     input logic [1:0] rv, input logic [1:0] fu, input logic cr,
                     input logic cvc, input logic ov, input logic ud);
    vec_t t;
    t.we = we; t.wvc = wvc; t.din = din; t.sh = sh; t.rvc = rvc;
    t.chk_data = cd; t.exp_data = ed; t.exp_rv = rv; t.exp_full = fu;
    t.exp_cr = cr; t.exp_cvc = cvc; t.exp_ovf = ov; t.exp_udf = ud;
    vq.push_back(t);
  endtask

  // Drive one cycle; data_o is the head being popped, sampled before the edge
  task automatic run_vec(input vec_t t, input string tag);
    write_en_i = t.we; wr_vc_i = t.wvc; data_i = t.din;
    shift_i = t.sh; rd_vc_i = t.rvc;
    #1;
    if (t.chk_data) chk({tag, " data_o"}, 32'(data_o), 32'(t.exp_data));
    @(posedge clk); #1;
    chk({tag, " read_valid_o"}, 32'(read_valid_o), 32'(t.exp_rv));
    chk({tag, " full_o"}, 32'(full_o), 32'(t.exp_full));
    chk({tag, " credit_o"}, 32'(credit_o), 32'(t.exp_cr));
    if (t.exp_cr) chk({tag, " credit_vc_o"}, 32'(credit_vc_o), 32'(t.exp_cvc));
    chk({tag, " ovf_err_o"}, 32'(ovf_err_o), 32'(t.exp_ovf));
    chk({tag, " udf_err_o"}, 32'(udf_err_o), 32'(t.exp_udf));
    if (credit_o) credits++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " read_valid_o"}, 32'(read_valid_o), 32'd0);
    chk({tag, " full_o"}, 32'(full_o), 32'd0);
    chk({tag, " credit_o"}, 32'(credit_o), 32'd0);
    chk({tag, " credit_vc_o"}, 32'(credit_vc_o), 32'd0);
    chk({tag, " ovf_err_o"}, 32'(ovf_err_o), 32'd0);
    chk({tag, " udf_err_o"}, 32'(udf_err_o), 32'd0);
`ifdef NOC_INPORT_STATS_EN
    chk({tag, " flit_cnt_o"}, 32'(flit_cnt_o[0] | flit_cnt_o[1]), 32'd0);
    chk({tag, " drop_cnt_o"}, drop_cnt_o, 32'd0);
`endif
  endtask

  initial begin
    vec_t t;
    rst_n = 1'b0; write_en_i = 1'b0; shift_i = 1'b0;
    wr_vc_i = 1'b0; rd_vc_i = 1'b0; data_i = '0;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill VC1 then drain in order with VC1 credits
    for (int i = 1; i <= 5; i++)
      add(1, 1, 16'(i), 0, 0, 0, 0, 2'b10, (i == 5) ? 2'b10 : 2'b00, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++)
      add(0, 0, 0, 1, 1, 1, 16'(i), (i == 5) ? 2'b00 : 2'b10, 2'b00, 1, 1, 0, 0);
    // Underflow on empty VC1
    add(0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1);
    // VC isolation
    for (int i = 0; i < 4; i++) begin
      add(1, 0, 16'h00A0 + 16'(i), 0, 0, 0, 0, (i == 0) ? 2'b01 : 2'b11, 2'b00, 0, 0, 0, 1);
      add(1, 1, 16'h00B0 + 16'(i), 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 0, 1);
    end
    for (int i = 0; i < 4; i++)
      add(0, 0, 0, 1, 1, 1, 16'h00B0 + 16'(i), (i == 3) ? 2'b01 : 2'b11, 2'b00, 1, 1, 0, 1);
    for (int i = 0; i < 4; i++)
      add(0, 0, 0, 1, 0, 1, 16'h00A0 + 16'(i), (i == 3) ? 2'b00 : 2'b01, 2'b00, 1, 0, 0, 1);
    // Overflow, then push+pop at full, then drain to prove contents
    for (int i = 1; i <= 5; i++)
      add(1, 0, 16'h00C0 + 16'(i), 0, 0, 0, 0, 2'b01, (i == 5) ? 2'b01 : 2'b00, 0, 0, 0, 1);
    add(1, 0, 16'hBEEF, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 1, 1);
    add(1, 0, 16'h00D0, 1, 0, 1, 16'h00C1, 2'b01, 2'b01, 1, 0, 1, 1);
    for (int i = 2; i <= 5; i++)
      add(0, 0, 0, 1, 0, 1, 16'h00C0 + 16'(i), 2'b01, 2'b00, 1, 0, 1, 1);
    add(0, 0, 0, 1, 0, 1, 16'h00D0, 2'b00, 2'b00, 1, 0, 1, 1);
    // Push+pop at count 1, cross-VC independence, no bypass into empty VC
    add(1, 0, 16'h00E0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 1, 1);
    add(1, 0, 16'h00E1, 1, 0, 1, 16'h00E0, 2'b01, 2'b00, 1, 0, 1, 1);
    add(0, 0, 0, 1, 0, 1, 16'h00E1, 2'b00, 2'b00, 1, 0, 1, 1);
    add(1, 0, 16'h00E2, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 1, 1);
    add(1, 1, 16'h00F0, 1, 0, 1, 16'h00E2, 2'b10, 2'b00, 1, 0, 1, 1);
    add(0, 0, 0, 1, 1, 1, 16'h00F0, 2'b00, 2'b00, 1, 1, 1, 1);
    add(1, 1, 16'h00F1, 1, 1, 0, 0, 2'b10, 2'b00, 0, 0, 1, 1);
    add(0, 0, 0, 1, 1, 1, 16'h00F1, 2'b00, 2'b00, 1, 1, 1, 1);

    foreach (vq[i]) run_vec(vq[i], $sformatf("vec%0d", i));

    // Pointer wrap: 3 rounds of push 4 / pop 4 on VC0
    credits = 0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        t = '{1'b1, 1'b0, 16'h6000 + 16'(r * 16 + i), 1'b0, 1'b0, 1'b0, 16'h0,
              2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
        run_vec(t, $sformatf("wrap_r%0d_push%0d", r, i));
      end
      for (int i = 0; i < 4; i++) begin
        t = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 16'h6000 + 16'(r * 16 + i),
              (i == 3) ? 2'b00 : 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1};
        run_vec(t, $sformatf("wrap_r%0d_pop%0d", r, i));
      end
    end
    chk("wrap credit total", 32'(credits), 32'd12);
`ifdef NOC_INPORT_STATS_EN
    chk("flit_cnt_o[0]", flit_cnt_o[0], 32'd25);
    chk("flit_cnt_o[1]", flit_cnt_o[1], 32'd11);
    chk("drop_cnt_o", drop_cnt_o, 32'd1);
`endif

    // Mid-stream async reset with 3 flits queued and a credit pending
    for (int i = 0; i < 4; i++) begin
      t = '{1'b1, 1'b0, 16'h7000 + 16'(i), 1'b0, 1'b0, 1'b0, 16'h0,
            2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
      run_vec(t, $sformatf("rst_fill%0d", i));
    end
    t = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 16'h7000,
          2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1};
    run_vec(t, "rst_pop");
    write_en_i = 1'b0; shift_i = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("post_reset%0d read_valid_o", i), 32'(read_valid_o), 32'd0);
      chk($sformatf("post_reset%0d credit_o", i), 32'(credit_o), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
